cpu_bus_initiator: RTL and testbench

// - 68020-style local bus master. Drives the AS20/DS20/RW20/SIZ/A cycle that the fastmem and Zorro II autoconfig responders answer.
// - Turns single-beat requests from an on-board engine (IDE DMA, autoconfig host sequencer, bench) into one bus cycle.
// - Terminates each cycle on the responder's active-low ready, or on a timeout.
// - Returns read data together with ACK or ERR.

---
 rtl/tf_bus_pkg.sv | 22 ++
 rtl/bus_timeout_counter.sv | 30 +++
 rtl/cpu_bus_initiator.sv | 139 +++++++++++++
 tb/tb_cpu_bus_initiator.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/tf_bus_pkg.sv
// Shared definitions for the 68020-style local bus: size codes, initiator
// state encoding and default timing parameters.
package tf_bus_pkg;

  localparam logic [1:0] SIZ_LONG  = 2'b00;
  localparam logic [1:0] SIZ_BYTE  = 2'b01;
  localparam logic [1:0] SIZ_WORD  = 2'b10;
  localparam logic [1:0] SIZ_3BYTE = 2'b11;

  localparam int DEFAULT_TIMEOUT  = 64;
  localparam int DEFAULT_IDLE_GAP = 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_STROBE  = 3'd2,
    ST_WAIT    = 3'd3,
    ST_TERM    = 3'd4,
    ST_RECOVER = 3'd5
  } init_state_t;

endpackage

// File: rtl/bus_timeout_counter.sv
// Bus cycle watchdog: counts enabled cycles from a clear and flags the
// terminal count TIMEOUT_CYCLES - 1; holds there until cleared.
module bus_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] TERMINAL = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i && (cnt_q != TERMINAL)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire_o = (cnt_q == TERMINAL);

endmodule

// File: rtl/cpu_bus_initiator.sv
// Single-beat 68020-style bus master: runs one AS20/DS20 cycle per request,
// ends it on READY_N or on timeout, then holds AS20 high for IDLE_GAP cycles.
//
// state   | meaning
// IDLE    | waiting for REQ, request captured on REQ
// ADDR    | A/SIZ/RW20 (and write data) driven, strobes high
// STROBE  | AS20 low; DS20 low for reads; watchdog starts
// WAIT    | strobes low, READY_N or watchdog ends the cycle
// TERM    | strobes released, ACK or ERR pulse
// RECOVER | AS20 held high before the next capture
module cpu_bus_initiator
  import tf_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int IDLE_GAP       = DEFAULT_IDLE_GAP
) (
  input  logic        clkcpu_i,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic        req_rw_i,
  input  logic [23:0] req_addr_i,
  input  logic [1:0]  req_siz_i,
  input  logic [31:0] req_wdata_i,
  output logic        ack_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic        busy_o,
  output logic [23:0] a_o,
  output logic [1:0]  siz_o,
  output logic        as20_o,
  output logic        ds20_o,
  output logic        rw20_o,
  output logic [31:0] d_out_o,
  output logic        d_oe_o,
  input  logic [31:0] d_in_i,
  input  logic        ready_n_i
);

  localparam int GW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

  init_state_t   state_q, state_d;
  logic [23:0]   addr_q;
  logic [1:0]    siz_q;
  logic          rw_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          ok_q;
  logic [GW-1:0] gap_q;
  logic          expire;

  // Watchdog reads 0 during STROBE, so it hits TIMEOUT_CYCLES - 1 on the
  // last WAIT cycle, TIMEOUT_CYCLES cycles after AS20 fell.
  bus_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i   (clkcpu_i),
    .rst_i   (reset_i),
    .clear_i (state_q == ST_ADDR),
    .enable_i((state_q == ST_STROBE) || (state_q == ST_WAIT)),
    .expire_o(expire)
  );

  always_ff @(posedge clkcpu_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      siz_q   <= SIZ_LONG;
      rw_q    <= 1'b1;
      wdata_q <= '0;
      rdata_q <= '0;
      ok_q    <= 1'b0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && req_i) begin
        addr_q  <= req_addr_i;
        siz_q   <= req_siz_i;
        rw_q    <= req_rw_i;
        wdata_q <= req_wdata_i;
      end
      if (state_q == ST_WAIT) begin
        ok_q <= ~ready_n_i;
        if (!ready_n_i && rw_q) rdata_q <= d_in_i;
      end
      if (state_q == ST_TERM) begin
        gap_q <= GW'(IDLE_GAP - 1);
      end else if ((state_q == ST_RECOVER) && (gap_q != '0)) begin
        gap_q <= gap_q - 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (req_i) state_d = ST_ADDR;
      ST_ADDR:    state_d = ST_STROBE;
      ST_STROBE:  state_d = ST_WAIT;
      ST_WAIT:    if (!ready_n_i || expire) state_d = ST_TERM;
      ST_TERM:    state_d = ST_RECOVER;
      ST_RECOVER: if (gap_q == '0) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    as20_o = 1'b1;
    ds20_o = 1'b1;
    d_oe_o = 1'b0;
    ack_o  = 1'b0;
    err_o  = 1'b0;
    busy_o = (state_q != ST_IDLE);
    unique case (state_q)
      ST_ADDR:   d_oe_o = ~rw_q;
      ST_STROBE: begin
        as20_o = 1'b0;
        ds20_o = ~rw_q;
        d_oe_o = ~rw_q;
      end
      ST_WAIT: begin
        as20_o = 1'b0;
        ds20_o = 1'b0;
        d_oe_o = ~rw_q;
      end
      ST_TERM: begin
        ack_o = ok_q;
        err_o = ~ok_q;
      end
      default: ;
    endcase
  end

  assign a_o     = addr_q;
  assign siz_o   = siz_q;
  assign rw20_o  = rw_q;
  assign d_out_o = wdata_q;
  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_cpu_bus_initiator.sv
// Directed bench for cpu_bus_initiator: stimulus pushes expected responses,
// a negedge monitor pops and checks them on every ACK/ERR.
module tb_cpu_bus_initiator;
  import tf_bus_pkg::*;

  logic        clk, rst, req, req_rw;
  logic [23:0] req_addr;
  logic [1:0]  req_siz;
  logic [31:0] req_wdata, d_in;
  logic        ready_n;
  logic        ack, err, busy, as20, ds20, rw20, d_oe;
  logic [31:0] rdata, d_out;
  logic [23:0] a;
  logic [1:0]  siz;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   fall_cyc = 0;
  int   rise_cyc = 0;
  int   last_gap = 0;
  logic prev_as  = 1'b1;
  logic prev_resp = 1'b0;

  cpu_bus_initiator dut (
    .clkcpu_i   (clk),
    .reset_i    (rst),
    .req_i      (req),
    .req_rw_i   (req_rw),
    .req_addr_i (req_addr),
    .req_siz_i  (req_siz),
    .req_wdata_i(req_wdata),
    .ack_o      (ack),
    .err_o      (err),
    .rdata_o    (rdata),
    .busy_o     (busy),
    .a_o        (a),
    .siz_o      (siz),
    .as20_o     (as20),
    .ds20_o     (ds20),
    .rw20_o     (rw20),
    .d_out_o    (d_out),
    .d_oe_o     (d_oe),
    .d_in_i     (d_in),
    .ready_n_i  (ready_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: latency is counted in cycles from the AS20 falling cycle.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (prev_as && !as20) begin
      fall_cyc = cyc;
      last_gap = cyc - rise_cyc;
    end
    if (!prev_as && as20) rise_cyc = cyc;
    if (ack || err) begin
      chk("resp_pulse", 32'(prev_resp), 32'd0);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: got ack=%0b err=%0b, expected none (t=%0t)", ack, err, $time);
      end else begin
        e = sb.pop_front();
        chk("resp_err", 32'(err), 32'(e.err));
        chk("resp_ack", 32'(ack), 32'(!e.err));
        chk("resp_rdata", rdata, e.rdata);
        chk("resp_lat", 32'(cyc - fall_cyc), 32'(e.lat));
      end
    end
    prev_as   = as20;
    prev_resp = ack || err;
  end

  // Runs one request starting in an IDLE cycle. READY_N goes low rdy_at
  // cycles after AS20 falls; pre_low also holds it low through ADDR/STROBE.
  task automatic run_txn(input logic rw, input logic [23:0] addr, input logic [1:0] sz,
                         input logic [31:0] wdata, input logic [31:0] din, input int rdy_at,
                         input bit pre_low, input bit exp_err, input logic [31:0] exp_rdata,
                         input int exp_lat, input bit keep_req, output int n_cyc);
    exp_t e;
    int   n;
    bit   done;
    e.err = exp_err; e.rdata = exp_rdata; e.lat = exp_lat;
    sb.push_back(e);
    req = 1'b1; req_rw = rw; req_addr = addr; req_siz = sz; req_wdata = wdata;
    d_in = din;
    ready_n = pre_low ? 1'b0 : 1'b1;
    n = -1; done = 1'b0; n_cyc = 0;
    while (!done && n_cyc < 200) begin
      tick();
      n_cyc++;
      if (n < 0 && !as20) n = 0;
      else if (n >= 0) n++;
      if (ack || err) begin
        done = 1'b1;
        chk("term_as", 32'(as20), 32'd1);
        chk("term_ds", 32'(ds20), 32'd1);
        chk("term_oe", 32'(d_oe), 32'd0);
        if (!keep_req) req = 1'b0;
        ready_n = 1'b1;
      end else begin
        if (n_cyc == 1) begin
          chk("addr_a", 32'(a), 32'(addr));
          chk("addr_siz", 32'(siz), 32'(sz));
          chk("addr_rw", 32'(rw20), 32'(rw));
          chk("addr_as", 32'(as20), 32'd1);
          chk("addr_oe", 32'(d_oe), 32'(!rw));
          chk("addr_busy", 32'(busy), 32'd1);
          if (!rw) chk("addr_dout", d_out, wdata);
        end
        if (n == 0) chk("strobe_ds", 32'(ds20), 32'(rw ? 1'b0 : 1'b1));
        if (n == 1) chk("wait_ds", 32'(ds20), 32'd0);
        if (!rw && n >= 0) chk("wr_oe", 32'(d_oe), 32'd1);
        if (n < 1) ready_n = pre_low ? 1'b0 : 1'b1;
        else       ready_n = (n >= rdy_at) ? 1'b0 : 1'b1;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL txn_bound: got no ACK/ERR in %0d cycles, expected a response", n_cyc);
      req = 1'b0;
      ready_n = 1'b1;
    end
  endtask

  initial begin
    int nc;
    rst = 1'b1; req = 1'b0; req_rw = 1'b1; req_addr = '0; req_siz = '0;
    req_wdata = '0; d_in = '0; ready_n = 1'b1;
    #3;
    chk("rst_as", 32'(as20), 32'd1);
    chk("rst_ds", 32'(ds20), 32'd1);
    chk("rst_rw", 32'(rw20), 32'd1);
    chk("rst_oe", 32'(d_oe), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_a", 32'(a), 32'd0);
    chk("rst_siz", 32'(siz), 32'd0);
    chk("rst_dout", d_out, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // Long read, READY_N low 2 cycles after AS20 falls.
    run_txn(1'b1, 24'h200000, SIZ_LONG, 32'h0, 32'hDEADBEEF, 2, 1'b0, 1'b0, 32'hDEADBEEF, 3, 1'b0, nc);
    tick(); tick();
    // Byte write: RDATA must keep the last read value.
    run_txn(1'b0, 24'h400003, SIZ_BYTE, 32'h00000055, 32'hCAFEF00D, 2, 1'b0, 1'b0, 32'hDEADBEEF, 3, 1'b0, nc);
    tick(); tick();
    // Unmapped read: ERR TIMEOUT_CYCLES after AS20 falls, RDATA unchanged.
    run_txn(1'b1, 24'hA00000, SIZ_LONG, 32'h0, 32'h12345678, 1000, 1'b0, 1'b1, 32'hDEADBEEF, 64, 1'b0, nc);
    tick(); tick();
    // Minimum latency: capture edge to ACK is 4 cycles.
    run_txn(1'b1, 24'h000010, SIZ_WORD, 32'h0, 32'h0000A5A5, 1, 1'b0, 1'b0, 32'h0000A5A5, 2, 1'b0, nc);
    chk("min_latency", 32'(nc), 32'd4);
    tick(); tick();
    // Stale READY_N low through ADDR/STROBE must not end the cycle.
    run_txn(1'b1, 24'h000020, SIZ_LONG, 32'h0, 32'h11223344, 3, 1'b1, 1'b0, 32'h11223344, 4, 1'b0, nc);
    tick(); tick();
    // READY_N low on the timeout cycle: ACK wins.
    run_txn(1'b1, 24'hA00004, SIZ_LONG, 32'h0, 32'h55667788, 63, 1'b0, 1'b0, 32'h55667788, 64, 1'b0, nc);
    tick(); tick();
    // Back-to-back reads with REQ held across ACK.
    run_txn(1'b1, 24'h000100, SIZ_LONG, 32'h0, 32'h01010101, 1, 1'b0, 1'b0, 32'h01010101, 2, 1'b1, nc);
    tick();
    chk("b2b_recover_busy", 32'(busy), 32'd1);
    tick();
    chk("b2b_idle_busy", 32'(busy), 32'd0);
    chk("b2b_idle_as", 32'(as20), 32'd1);
    run_txn(1'b1, 24'h000104, SIZ_LONG, 32'h0, 32'h02020202, 2, 1'b0, 1'b0, 32'h02020202, 3, 1'b0, nc);
    chk("b2b_as_gap", 32'(last_gap), 32'd4);
    tick(); tick();

    // Reset in WAIT of a write: strobes released at once, no response.
    req = 1'b1; req_rw = 1'b0; req_addr = 24'h400000; req_siz = SIZ_LONG;
    req_wdata = 32'hA5A5A5A5; ready_n = 1'b1;
    for (int k = 0; k < 8 && as20; k++) tick();
    tick();
    chk("rstw_pre_ds", 32'(ds20), 32'd0);
    chk("rstw_pre_oe", 32'(d_oe), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstw_as", 32'(as20), 32'd1);
    chk("rstw_ds", 32'(ds20), 32'd1);
    chk("rstw_oe", 32'(d_oe), 32'd0);
    chk("rstw_busy", 32'(busy), 32'd0);
    chk("rstw_ack", 32'(ack), 32'd0);
    chk("rstw_err", 32'(err), 32'd0);
    chk("rstw_rdata", rdata, 32'd0);
    req = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    run_txn(1'b1, 24'h200000, SIZ_LONG, 32'h0, 32'h0BADF00D, 2, 1'b0, 1'b0, 32'h0BADF00D, 3, 1'b0, nc);
    repeat (4) tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
